// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline stage types, state encoding and payload structs
package pipe_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_ONE   = 2'd1,
    PS_TWO   = 2'd2
  } pipe_state_t;

  // Replicated to the payload width; an all-zero payload decodes as a NOP.
  localparam bit PIPE_NOP = 1'b0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic        mem_rd;
    logic        mem_wr;
    logic        reg_wr;
  } id_ex_t;

  typedef struct packed {
    logic [31:0] alu_res;
    logic [31:0] store_val;
    logic [4:0]  rd;
    logic        mem_rd;
    logic        mem_wr;
    logic        reg_wr;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] wb_val;
    logic [4:0]  rd;
    logic        reg_wr;
  } mem_wb_t;

  function automatic logic [1:0] state_occ(input pipe_state_t s);
    case (s)
      PS_ONE:  state_occ = 2'd1;
      PS_TWO:  state_occ = 2'd2;
      default: state_occ = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// rtl/pipe_skid_buf.sv - two-entry skid buffer; in_ready comes straight from the state flop
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int CLR_DATA = 1
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occ
);

  pipe_state_t      state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_fire, out_fire;

  assign in_ready  = (state_q != PS_TWO);
  assign out_valid = (state_q != PS_EMPTY);
  assign out_data  = main_q;
  assign occ       = state_occ(state_q);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= PS_EMPTY;
      if (CLR_DATA != 0) begin
        main_q <= {WIDTH{PIPE_NOP}};
        skid_q <= {WIDTH{PIPE_NOP}};
      end
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // A flush still lets the current output transfer complete; only the state is dropped.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = PS_EMPTY;
      if (CLR_DATA != 0) begin
        main_d = {WIDTH{PIPE_NOP}};
        skid_d = {WIDTH{PIPE_NOP}};
      end
    end else begin
      case (state_q)
        PS_EMPTY: begin
          if (in_fire) begin
            main_d  = in_data;
            state_d = PS_ONE;
          end
        end
        PS_ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            skid_d  = in_data;
            state_d = PS_TWO;
          end else if (out_fire) begin
            state_d = PS_EMPTY;
          end
        end
        PS_TWO: begin
          if (out_fire) begin
            main_d  = skid_q;
            state_d = PS_ONE;
          end
        end
        default: state_d = PS_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - elastic pipeline stage register, single-entry or two-entry skid
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int SKID     = 0,
  parameter int CLR_DATA = 1
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occ
);

  if (SKID != 0) begin : g_skid
    pipe_skid_buf #(
      .WIDTH    (WIDTH),
      .CLR_DATA (CLR_DATA)
    ) u_skid_buf (
      .CLK       (CLK),
      .nRST      (nRST),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .occ       (occ)
    );
  end else begin : g_single
    logic             full_q;
    logic [WIDTH-1:0] data_q;

    // Combinational ready lets a full stage refill in the same cycle it drains.
    assign in_ready  = !full_q || out_ready;
    assign out_valid = full_q;
    assign out_data  = data_q;
    assign occ       = {1'b0, full_q};

    always_ff @(posedge CLK) begin
      if (!nRST || flush) begin
        full_q <= 1'b0;
        if (CLR_DATA != 0) begin
          data_q <= {WIDTH{PIPE_NOP}};
        end
      end else if (in_valid && in_ready) begin
        full_q <= 1'b1;
        data_q <= in_data;
      end else if (out_ready) begin
        full_q <= 1'b0;
      end
    end
  end

endmodule
